// File: rtl/mask_cache_writer.sv
// mask_cache_writer: producer end of the 256-bit mask cache FIFO.
// Packs host mask words (first word in the MSBs) into FIFO entries, writes them
// under FIFO backpressure, and tracks beat/row/pattern progress for one frame.
module mask_cache_writer #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 256,
  parameter int ROW_BEATS = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [CNT_W-1:0] num_row,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] fifo_din,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] pat_cnt,
  output logic [CNT_W-1:0] row_cnt
);

  localparam int WPB    = OUT_W / IN_W;
  localparam int IDX_W  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int BEAT_W = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WPB - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(ROW_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_frame_done;
  logic [OUT_W-1:0]   r_fifo_din;
  logic [OUT_W-1:0]   r_pack;
  logic [IDX_W-1:0]   r_idx;
  logic [BEAT_W-1:0]  r_beat;
  logic [CNT_W-1:0]   r_row_cnt;
  logic [CNT_W-1:0]   r_pat_cnt;
  logic [CNT_W-1:0]   r_num_pat;
  logic [CNT_W-1:0]   r_num_row;

  logic [OUT_W-1:0]   w_pack_nxt;
  logic               w_accept;
  logic               w_wr_fire;
  logic               w_last_beat;
  logic               w_last_row;
  logic               w_last_pat;
  logic               w_frame_end;

  // The write strobe follows fifo_full and abort in the same cycle so a write
  // is never issued into a full FIFO and an abort suppresses a pending write.
  assign w_wr_fire   = (r_state == S_WRITE) && !fifo_full && !abort;
  assign w_accept    = (r_state == S_PACK) && r_in_ready && in_valid;
  assign w_last_beat = (r_beat == BEAT_LAST);
  assign w_last_row  = (r_row_cnt == (r_num_row - CNT_W'(1)));
  assign w_last_pat  = ((r_pat_cnt + CNT_W'(1)) == r_num_pat);
  assign w_frame_end = w_last_beat && w_last_row && w_last_pat;

  assign in_ready   = r_in_ready;
  assign fifo_din   = r_fifo_din;
  assign fifo_wr_en = w_wr_fire;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign pat_cnt    = r_pat_cnt;
  assign row_cnt    = r_row_cnt;

  // Merge the incoming host word into its slot; slot 0 is the most significant.
  always_comb begin
    w_pack_nxt = r_pack;
    for (int i = 0; i < WPB; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_pack_nxt[OUT_W-1-IN_W*i -: IN_W] = in_data;
      end else begin
        w_pack_nxt[OUT_W-1-IN_W*i -: IN_W] = r_pack[OUT_W-1-IN_W*i -: IN_W];
      end
    end
  end

  // Frame control FSM: packing, FIFO writes, progress counters and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_fifo_din   <= '0;
      r_pack       <= '0;
      r_idx        <= '0;
      r_beat       <= '0;
      r_row_cnt    <= '0;
      r_pat_cnt    <= '0;
      r_num_pat    <= '0;
      r_num_row    <= '0;
    end else if (abort) begin
      // Abort wins over everything; progress counters keep their values.
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_pack       <= '0;
      r_idx        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_pat <= num_pat;
            r_num_row <= num_row;
            r_pat_cnt <= '0;
            r_row_cnt <= '0;
            r_beat    <= '0;
            r_idx     <= '0;
            r_pack    <= '0;
            r_busy    <= 1'b1;
            if ((num_pat == CNT_W'(0)) || (num_row == CNT_W'(0))) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_PACK;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_PACK: begin
          if (w_accept) begin
            if (r_idx == IDX_LAST) begin
              r_fifo_din <= w_pack_nxt;
              r_pack     <= '0;
              r_idx      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_WRITE;
            end else begin
              r_pack <= w_pack_nxt;
              r_idx  <= r_idx + IDX_W'(1);
            end
          end
        end
        S_WRITE: begin
          if (!fifo_full) begin
            if (w_last_beat) begin
              r_beat <= '0;
              if (w_last_row) begin
                r_row_cnt <= '0;
                r_pat_cnt <= r_pat_cnt + CNT_W'(1);
              end else begin
                r_row_cnt <= r_row_cnt + CNT_W'(1);
              end
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
            if (w_frame_end) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_PACK;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mask_cache_writer.sv
// Scoreboard bench for mask_cache_writer: the host driver builds expected FIFO
// entries from the words it hands over; a monitor checks every FIFO write.
module tb_mask_cache_writer;

  localparam int IN_W      = 32;
  localparam int OUT_W     = 256;
  localparam int ROW_BEATS = 2;
  localparam int CNT_W     = 16;
  localparam int WPB       = OUT_W / IN_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  num_pat = '0;
  logic [CNT_W-1:0]  num_row = '0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OUT_W-1:0]  fifo_din;
  logic              fifo_wr_en;
  logic              fifo_full = 1'b0;
  logic              busy;
  logic              frame_done;
  logic [CNT_W-1:0]  pat_cnt;
  logic [CNT_W-1:0]  row_cnt;

  mask_cache_writer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .ROW_BEATS(ROW_BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_pat(num_pat), .num_row(num_row),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .busy(busy), .frame_done(frame_done), .pat_cnt(pat_cnt), .row_cnt(row_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int exp_wr_cyc = -1;
  bit lat_chk = 1'b1;
  bit noise_stop = 1'b0;
  bit prev_done = 1'b0;
  logic [OUT_W-1:0] exp_q[$];
  logic [IN_W-1:0]  part_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference entry for eight consecutive word values starting at base.
  function automatic logic [OUT_W-1:0] seq_entry(input logic [IN_W-1:0] base);
    logic [OUT_W-1:0] e;
    e = '0;
    for (int i = 0; i < WPB; i++) e = (e << IN_W) | OUT_W'(base + 32'(i));
    return e;
  endfunction

  // Model: every WPB accepted words form one entry, earliest word on top.
  task automatic push_word(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] e;
    part_q.push_back(d);
    acc_cnt++;
    if (part_q.size() == WPB) begin
      e = '0;
      foreach (part_q[i]) e = (e << IN_W) | OUT_W'(part_q[i]);
      exp_q.push_back(e);
      exp_wr_cyc = cyc + 1;
      part_q.delete();
    end
  endtask

  // Cycle counter used for write-latency checks.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compare each FIFO write against the scoreboard, track frame_done.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (fifo_wr_en) begin
        wr_cnt++;
        chk("pending_entry_at_write", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("fifo_din", fifo_din, exp_q.pop_front());
        chk("in_ready_during_write", in_ready, 0);
        if (lat_chk) chk("write_latency", cyc, exp_wr_cyc);
      end
      if (frame_done) begin
        done_cnt++;
        chk("frame_done_single_cycle", prev_done, 0);
      end
      prev_done = frame_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic send_words(input int n, input logic [IN_W-1:0] base, input int duty, input bit rnd);
    int sent;
    int guard;
    logic [IN_W-1:0] w;
    sent = 0;
    guard = 0;
    w = rnd ? $urandom : base;
    while (sent < n && guard < 20000) begin
      in_data  = w;
      in_valid = ($urandom_range(99) < duty);
      @(negedge clk);
      if (in_valid && in_ready) begin
        push_word(w);
        sent++;
        w = rnd ? $urandom : base + 32'(sent);
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    chk("words_sent", sent, n);
  endtask

  task automatic do_start(input int p, input int r);
    start   = 1'b1;
    num_pat = CNT_W'(p);
    num_row = CNT_W'(r);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int k;
    k = 0;
    while (done_cnt == prev && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("frame_done_seen", done_cnt, prev + 1);
  endtask

  task automatic run_frame(input int p, input int r, input logic [IN_W-1:0] base,
                           input int duty, input bit rnd, input bit noise, input bit stall);
    int wr0;
    int dn0;
    int nw;
    int g;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    nw  = p * r * ROW_BEATS * WPB;
    lat_chk = !stall;
    do_start(p, r);
    chk("busy_after_start", busy, 1);
    noise_stop = 1'b0;
    acc_cnt = 0;
    fork
      begin
        send_words(nw, base, duty, rnd);
        noise_stop = 1'b1;
      end
      begin
        if (noise) begin
          while (!noise_stop) begin
            @(posedge clk); #1;
            if (busy && ($urandom_range(3) == 0)) begin
              start   = 1'b1;
              num_pat = CNT_W'($urandom_range(1, 7));
              num_row = CNT_W'($urandom_range(1, 7));
            end else begin
              start = 1'b0;
            end
          end
          start = 1'b0;
        end
      end
      begin
        if (stall) begin
          g = 0;
          while (acc_cnt < 3 * WPB && g < 2000) begin
            @(posedge clk);
            g++;
          end
          #1 fifo_full = 1'b1;
          for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("stall_no_write", fifo_wr_en, 0);
            chk("stall_in_ready_low", in_ready, 0);
            chk("stall_din_held", fifo_din, seq_entry(base + 32'(2 * WPB)));
            @(posedge clk); #1;
          end
          fifo_full = 1'b0;
          @(negedge clk);
          chk("write_on_full_release", fifo_wr_en, 1);
        end
      end
    join
    wait_done(dn0, 40);
    chk("write_count", wr_cnt - wr0, p * r * ROW_BEATS);
    chk("entries_left", exp_q.size(), 0);
    chk("pat_cnt_final", pat_cnt, p);
    chk("row_cnt_final", row_cnt, 0);
    chk("busy_after_done", busy, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("frame_done_pulses", done_cnt - dn0, 1);
    lat_chk = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_fifo_wr_en"}, fifo_wr_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_fifo_din"}, fifo_din, 0);
    chk({tag, "_pat_cnt"}, pat_cnt, 0);
    chk({tag, "_row_cnt"}, row_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int wr0;
    int dn0;
    int p;
    int r;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame: 2 patterns x 3 rows x 2 beats, incrementing words.
    run_frame(2, 3, 32'h0000_0000, 100, 1'b0, 1'b0, 1'b0);

    // Same load with the FIFO full for 20 cycles on the third write.
    run_frame(2, 3, 32'h0000_1000, 100, 1'b0, 1'b0, 1'b1);

    // Abort after 13 accepted words.
    wr0 = wr_cnt;
    dn0 = done_cnt;
    do_start(2, 3);
    send_words(13, 32'h0000_2000, 100, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    part_q.delete();
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_writes", wr_cnt - wr0, 1);
    chk("abort_entries_left", exp_q.size(), 0);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("abort_no_done", done_cnt - dn0, 0);
    chk("abort_pat_hold", pat_cnt, 0);
    chk("abort_row_hold", row_cnt, 0);
    run_frame(2, 3, 32'h0000_3000, 100, 1'b0, 1'b0, 1'b0);

    // Zero rows: straight to DONE with no writes.
    wr0 = wr_cnt;
    dn0 = done_cnt;
    in_valid = 1'b1;
    do_start(3, 0);
    chk("zero_busy_c1", busy, 1);
    chk("zero_done_c1", frame_done, 0);
    chk("zero_in_ready_c1", in_ready, 0);
    @(posedge clk); #1;
    chk("zero_done_c2", frame_done, 1);
    chk("zero_busy_c2", busy, 0);
    chk("zero_in_ready_c2", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("zero_done_c3", frame_done, 0);
    chk("zero_writes", wr_cnt - wr0, 0);
    chk("zero_pat_cnt", pat_cnt, 0);
    chk("zero_done_pulses", done_cnt - dn0, 1);

    // Random data, 50% valid duty, spurious starts while busy.
    for (int t = 0; t < 2; t++) begin
      p = $urandom_range(1, 3);
      r = $urandom_range(1, 3);
      run_frame(p, r, 32'h0, 50, 1'b1, 1'b1, 1'b0);
    end

    // Asynchronous reset while a write is stalled on a full FIFO.
    fifo_full = 1'b1;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    do_start(1, 1);
    send_words(WPB, 32'h0000_4000, 100, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("stalled_din", fifo_din, seq_entry(32'h0000_4000));
    chk("stalled_no_write", wr_cnt - wr0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    exp_q.delete();
    part_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    fifo_full = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("no_write_after_reset", wr_cnt - wr0, 0);
    chk("no_done_after_reset", done_cnt - dn0, 0);
    chk("idle_after_reset_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
